// File: rtl/register_file_scoreboard_pkg.sv
// Shared constants and helpers for the register file with busy scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package register_file_scoreboard_pkg;

    localparam int DEFAULT_W              = 32;
    localparam int DEFAULT_AW             = 4;
    localparam int DEFAULT_PC_STEP        = 4;
    localparam int DEFAULT_PC_READ_OFFSET = 8;

    localparam int NUM_WRITE_PORTS = 2;
    localparam int NUM_READ_PORTS  = 2;

    // Write port that wins when both ports target the same register.
    localparam int WRITE_WINNER_PORT = 1;

    // What the PC does in a given cycle.
    typedef enum logic [1:0] {
        PC_ADVANCE = 2'd0,
        PC_HOLD    = 2'd1,
        PC_LOAD    = 2'd2
    } pc_action_e;

    // The PC lives in the top register slot.
    function automatic int pc_index(input int aw);
        return (1 << aw) - 1;
    endfunction

endpackage

// File: rtl/register_file_scoreboard_reg.sv
// W-bit storage register with active-low asynchronous clear and write enable.
// Used for every GPR and for the program counter.
module register_asynchronous_reset_write_en
    import register_file_scoreboard_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         reset_asynchronous_n,
    input  logic         inp_write_enable,
    input  logic [W-1:0] inp_write_data,
    output logic [W-1:0] out_data
);

    logic [W-1:0] r_data;

    // Clear immediately on reset; otherwise load when enabled.
    always_ff @(posedge clk or negedge reset_asynchronous_n) begin
        if (!reset_asynchronous_n) begin
            r_data <= '0;
        end else if (inp_write_enable) begin
            r_data <= inp_write_data;
        end
    end

    assign out_data = r_data;

endmodule

// File: rtl/register_file_scoreboard.sv
// Register file with a hard-wired PC in the top slot, two read ports, two
// prioritised write ports and a per-GPR busy scoreboard for hazard detection.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module register_file_scoreboard
    import register_file_scoreboard_pkg::*;
#(
    parameter int W              = DEFAULT_W,
    parameter int AW             = DEFAULT_AW,
    parameter int PC_STEP        = DEFAULT_PC_STEP,
    parameter int PC_READ_OFFSET = DEFAULT_PC_READ_OFFSET
) (
    input  logic          clk,
    input  logic          reset_asynchronous_n,
    input  logic [AW-1:0] inp_read_address0,
    input  logic [AW-1:0] inp_read_address1,
    output logic [W-1:0]  out_read_data0,
    output logic [W-1:0]  out_read_data1,
    output logic          out_busy0,
    output logic          out_busy1,
    input  logic          write_enable0,
    input  logic [AW-1:0] inp_write_address0,
    input  logic [W-1:0]  inp_write_data0,
    input  logic          write_enable1,
    input  logic [AW-1:0] inp_write_address1,
    input  logic [W-1:0]  inp_write_data1,
    input  logic          issue_valid,
    input  logic [AW-1:0] inp_issue_address,
    input  logic          pc_load,
    input  logic [W-1:0]  inp_pc_data,
    input  logic          pc_stall,
    output logic [W-1:0]  out_pc
);

    localparam int NREG       = 1 << AW;
    localparam int NGPR       = NREG - 1;
    localparam int PC_IDX     = pc_index(AW);
    localparam int LOSER_PORT = 1 - WRITE_WINNER_PORT;

    localparam logic [AW-1:0] PC_ADDR     = AW'(PC_IDX);
    localparam logic [W-1:0]  PC_STEP_W   = W'(PC_STEP);
    localparam logic [W-1:0]  PC_OFFSET_W = W'(PC_READ_OFFSET);

    // Write ports gathered into arrays so the decode can be indexed by priority.
    logic          w_wr_en   [NUM_WRITE_PORTS];
    logic [AW-1:0] w_wr_addr [NUM_WRITE_PORTS];
    logic [W-1:0]  w_wr_data [NUM_WRITE_PORTS];

    logic [AW-1:0] w_rd_addr [NUM_READ_PORTS];
    logic [W-1:0]  w_rd_data [NUM_READ_PORTS];
    logic          w_rd_busy [NUM_READ_PORTS];

    // Slot NREG-1 carries the PC so the read mux never indexes out of range.
    logic [W-1:0]    w_reg_q [NREG];
    logic [NGPR-1:0] w_gpr_we;
    logic [NGPR-1:0] w_issue_hit;
    logic [NGPR-1:0] w_busy_next;
    logic [NGPR-1:0] r_busy;
    logic [NREG-1:0] w_busy_vec;

    logic [W-1:0] w_pc_q;
    logic [W-1:0] w_pc_next;
    logic         w_pc_we;
    pc_action_e   w_pc_action;

    assign w_wr_en[0]   = write_enable0;
    assign w_wr_addr[0] = inp_write_address0;
    assign w_wr_data[0] = inp_write_data0;
    assign w_wr_en[1]   = write_enable1;
    assign w_wr_addr[1] = inp_write_address1;
    assign w_wr_data[1] = inp_write_data1;

    assign w_rd_addr[0] = inp_read_address0;
    assign w_rd_addr[1] = inp_read_address1;

    genvar gi;

    // ------------------------------------------------------------------
    // GPR write decode, storage and scoreboard next-state. The PC slot is
    // not part of this loop, so writes and issues addressed to it vanish.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NGPR; gi++) begin : g_gpr
            localparam logic [AW-1:0] L_ADDR = AW'(gi);

            logic         w_hit_winner;
            logic         w_hit_loser;
            logic [W-1:0] w_data;

            assign w_hit_winner = w_wr_en[WRITE_WINNER_PORT] &&
                                  (w_wr_addr[WRITE_WINNER_PORT] == L_ADDR);
            assign w_hit_loser  = w_wr_en[LOSER_PORT] &&
                                  (w_wr_addr[LOSER_PORT] == L_ADDR);
            assign w_gpr_we[gi] = w_hit_winner || w_hit_loser;
            assign w_data       = w_hit_winner ? w_wr_data[WRITE_WINNER_PORT]
                                               : w_wr_data[LOSER_PORT];

            // A same-cycle issue beats a commit: the new producer owns the register.
            assign w_issue_hit[gi] = issue_valid && (inp_issue_address == L_ADDR);
            assign w_busy_next[gi] = w_issue_hit[gi] | (r_busy[gi] & ~w_gpr_we[gi]);

            register_asynchronous_reset_write_en #(
                .W (W)
            ) u_gpr (
                .clk                  (clk),
                .reset_asynchronous_n (reset_asynchronous_n),
                .inp_write_enable     (w_gpr_we[gi]),
                .inp_write_data       (w_data),
                .out_data             (w_reg_q[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Program counter: load beats stall beats advance, wrapping mod 2^W.
    // ------------------------------------------------------------------

    // Choose this cycle's PC action and the matching enable/next value.
    always_comb begin
        w_pc_action = PC_ADVANCE;
        if (pc_load) begin
            w_pc_action = PC_LOAD;
        end else if (pc_stall) begin
            w_pc_action = PC_HOLD;
        end

        w_pc_we   = 1'b1;
        w_pc_next = w_pc_q + PC_STEP_W;
        case (w_pc_action)
            PC_LOAD:  w_pc_next = inp_pc_data;
            PC_HOLD:  w_pc_we   = 1'b0;
            default:  ;
        endcase
    end

    register_asynchronous_reset_write_en #(
        .W (W)
    ) u_pc (
        .clk                  (clk),
        .reset_asynchronous_n (reset_asynchronous_n),
        .inp_write_enable     (w_pc_we),
        .inp_write_data       (w_pc_next),
        .out_data             (w_pc_q)
    );

    assign w_reg_q[PC_IDX] = w_pc_q;
    assign out_pc          = w_pc_q;

    // ------------------------------------------------------------------
    // Busy scoreboard: one bit per GPR; the PC is never busy.
    // ------------------------------------------------------------------

    // Register the busy bits; reset drops every pending writeback.
    always_ff @(posedge clk or negedge reset_asynchronous_n) begin
        if (!reset_asynchronous_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign w_busy_vec = {1'b0, r_busy};

    // ------------------------------------------------------------------
    // Read ports.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_read
            logic [W-1:0] w_data;
            logic         w_busy;

            // Register contents or PC+offset; optionally forward same-cycle writes.
            always_comb begin
                w_data = w_reg_q[w_rd_addr[gi]];
                w_busy = w_busy_vec[w_rd_addr[gi]];
                if (w_rd_addr[gi] == PC_ADDR) begin
                    w_data = w_pc_q + PC_OFFSET_W;
                    w_busy = 1'b0;
                end
`ifdef REGFILE_BYPASS_EN
                else begin
                    // Loser first so the winning port overrides it.
                    if (w_wr_en[LOSER_PORT] && (w_wr_addr[LOSER_PORT] == w_rd_addr[gi])) begin
                        w_data = w_wr_data[LOSER_PORT];
                        w_busy = issue_valid && (inp_issue_address == w_rd_addr[gi]);
                    end
                    if (w_wr_en[WRITE_WINNER_PORT] &&
                        (w_wr_addr[WRITE_WINNER_PORT] == w_rd_addr[gi])) begin
                        w_data = w_wr_data[WRITE_WINNER_PORT];
                        w_busy = issue_valid && (inp_issue_address == w_rd_addr[gi]);
                    end
                end
`endif
            end

            assign w_rd_data[gi] = w_data;
            assign w_rd_busy[gi] = w_busy;
        end
    endgenerate

    assign out_read_data0 = w_rd_data[0];
    assign out_read_data1 = w_rd_data[1];
    assign out_busy0      = w_rd_busy[0];
    assign out_busy1      = w_rd_busy[1];

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard: expectations are queued as the
// stimulus is applied and drained against the DUT outputs between clock edges.
module tb_register_file_scoreboard;

    localparam int K_PC    = 0;
    localparam int K_RD0   = 1;
    localparam int K_RD1   = 2;
    localparam int K_BUSY0 = 3;
    localparam int K_BUSY1 = 4;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_data0, rd_data1;
    logic        busy0, busy1;
    logic        we0, we1;
    logic [3:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        issue_valid;
    logic [3:0]  issue_addr;
    logic        pc_load, pc_stall;
    logic [31:0] pc_data_in;
    logic [31:0] pc_out;

    logic [31:0] exp_pc;

    always #50 clk = ~clk;

    register_file_scoreboard dut (
        .clk                  (clk),
        .reset_asynchronous_n (rst_n),
        .inp_read_address0    (rd_addr0),
        .inp_read_address1    (rd_addr1),
        .out_read_data0       (rd_data0),
        .out_read_data1       (rd_data1),
        .out_busy0            (busy0),
        .out_busy1            (busy1),
        .write_enable0        (we0),
        .inp_write_address0   (wa0),
        .inp_write_data0      (wd0),
        .write_enable1        (we1),
        .inp_write_address1   (wa1),
        .inp_write_data1      (wd1),
        .issue_valid          (issue_valid),
        .inp_issue_address    (issue_addr),
        .pc_load              (pc_load),
        .inp_pc_data          (pc_data_in),
        .pc_stall             (pc_stall),
        .out_pc               (pc_out)
    );

    task automatic push(input string tag, input int kind, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.kind  = kind;
        e.value = value;
        exp_q.push_back(e);
    endtask

    // Let combinational outputs settle, then compare every queued expectation.
    task automatic check_pending();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_PC:    obs = pc_out;
                K_RD0:   obs = rd_data0;
                K_RD1:   obs = rd_data1;
                K_BUSY0: obs = {31'b0, busy0};
                K_BUSY1: obs = {31'b0, busy1};
                default: obs = 'x;
            endcase
            checks++;
            assert (obs === e.value) else begin
                errors++;
                $error("FAIL %s: observed=0x%08h expected=0x%08h", e.tag, obs, e.value);
            end
            $display("check %-24s observed=0x%08h expected=0x%08h", e.tag, obs, e.value);
        end
    endtask

    // Advance one clock, tracking the expected PC from the controls in force.
    task automatic tick();
        if (!rst_n)        exp_pc = 32'h0;
        else if (pc_load)  exp_pc = pc_data_in;
        else if (!pc_stall) exp_pc = exp_pc + 32'd4;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rd_addr0 = '0; rd_addr1 = '0;
        we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        issue_valid = 1'b0; issue_addr = '0;
        pc_load = 1'b0; pc_stall = 1'b0; pc_data_in = '0;
        exp_pc = 32'h0;

        // Outputs while held in reset.
        #20;
        rd_addr0 = 4'd15; rd_addr1 = 4'd3;
        push("rst_pc", K_PC, 32'h0);
        push("rst_rd_pc", K_RD0, 32'h8);
        push("rst_rd_r3", K_RD1, 32'h0);
        push("rst_busy_r3", K_BUSY1, 32'h0);
        check_pending();

        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        push("pc_after_release", K_PC, exp_pc);
        check_pending();

        // Every GPR and busy bit cleared.
        for (int a = 0; a < 15; a++) begin
            rd_addr0 = 4'(a); rd_addr1 = 4'(14 - a);
            push($sformatf("zero_r%0d", a), K_RD0, 32'h0);
            push($sformatf("busy_zero_r%0d", 14 - a), K_BUSY1, 32'h0);
            check_pending();
        end

        // Idle advance: 4, 8, 12, PC read returns PC+8.
        rd_addr0 = 4'd15;
        for (int c = 0; c < 3; c++) begin
            tick();
            push("pc_idle", K_PC, exp_pc);
            push("pc_idle_read", K_RD0, exp_pc + 32'd8);
            check_pending();
        end

        // Both ports hit R3 in one cycle: port 1 wins.
        we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hA5A5_0001;
        we1 = 1'b1; wa1 = 4'd3; wd1 = 32'h0000_BEEF;
        rd_addr0 = 4'd3;
`ifdef REGFILE_BYPASS_EN
        push("r3_same_cycle", K_RD0, 32'h0000_BEEF);
`else
        push("r3_same_cycle", K_RD0, 32'h0000_0000);
`endif
        check_pending();
        tick();
        we0 = 1'b0; we1 = 1'b0;
        push("r3_collision", K_RD0, 32'h0000_BEEF);
        check_pending();

        // Independent writes on both ports.
        we0 = 1'b1; wa0 = 4'd4; wd0 = 32'h0000_0044;
        we1 = 1'b1; wa1 = 4'd6; wd1 = 32'h0000_0066;
        tick();
        we0 = 1'b0; we1 = 1'b0;
        rd_addr0 = 4'd4; rd_addr1 = 4'd6;
        push("r4_port0", K_RD0, 32'h0000_0044);
        push("r6_port1", K_RD1, 32'h0000_0066);
        check_pending();

        // Issue to R5, commit two cycles later.
        rd_addr1 = 4'd5;
        issue_valid = 1'b1; issue_addr = 4'd5;
        push("r5_busy_issue_cycle", K_BUSY1, 32'h0);
        check_pending();
        tick();
        issue_valid = 1'b0;
        push("r5_busy_c1", K_BUSY1, 32'h1);
        check_pending();
        tick();
        push("r5_busy_c2", K_BUSY1, 32'h1);
        we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h0000_0077;
`ifdef REGFILE_BYPASS_EN
        push("r5_busy_commit_cycle", K_BUSY1, 32'h0);
`else
        push("r5_busy_commit_cycle", K_BUSY1, 32'h1);
`endif
        check_pending();
        tick();
        we1 = 1'b0;
        push("r5_busy_cleared", K_BUSY1, 32'h0);
        push("r5_data", K_RD1, 32'h0000_0077);
        check_pending();

        // Issue and commit to R5 together: the bit ends set.
        issue_valid = 1'b1; issue_addr = 4'd5;
        we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h0000_0099;
`ifdef REGFILE_BYPASS_EN
        push("r5_issue_commit_now", K_BUSY1, 32'h1);
`else
        push("r5_issue_commit_now", K_BUSY1, 32'h0);
`endif
        check_pending();
        tick();
        issue_valid = 1'b0; we0 = 1'b0;
        push("r5_issue_commit_busy", K_BUSY1, 32'h1);
        push("r5_issue_commit_data", K_RD1, 32'h0000_0099);
        check_pending();

        // Stall, load while stalled, then resume.
        pc_load = 1'b1; pc_data_in = 32'h20;
        tick();
        pc_load = 1'b0; pc_stall = 1'b1;
        push("pc_load_20", K_PC, 32'h20);
        check_pending();
        tick();
        push("pc_stall_1", K_PC, 32'h20);
        check_pending();
        tick();
        push("pc_stall_2", K_PC, 32'h20);
        pc_load = 1'b1; pc_data_in = 32'h100;
        check_pending();
        tick();
        pc_load = 1'b0; pc_stall = 1'b0;
        push("pc_load_over_stall", K_PC, 32'h100);
        check_pending();
        tick();
        rd_addr1 = 4'd15;
        push("pc_resume", K_PC, 32'h104);
        push("pc_resume_read", K_RD1, 32'h10C);
        check_pending();

        // Wrap, with a write aimed at the PC index that must be ignored.
        pc_load = 1'b1; pc_data_in = 32'hFFFF_FFFC;
        tick();
        pc_load = 1'b0;
        we0 = 1'b1; wa0 = 4'd15; wd0 = 32'h0000_1234;
        push("pc_top", K_PC, 32'hFFFF_FFFC);
        push("pc_top_read_wrap", K_RD1, 32'h0000_0004);
        check_pending();
        tick();
        we0 = 1'b0;
        push("pc_wrap", K_PC, 32'h0);
        push("pc_write_ignored", K_RD1, 32'h8);
        check_pending();
        tick();
        push("pc_after_wrap", K_PC, exp_pc);
        check_pending();

        // Mid-operation asynchronous reset with R7 written and busy.
        we0 = 1'b1; wa0 = 4'd7; wd0 = 32'h0000_0055;
        tick();
        we0 = 1'b0;
        issue_valid = 1'b1; issue_addr = 4'd7;
        tick();
        issue_valid = 1'b0;
        rd_addr0 = 4'd7;
        push("r7_before_reset", K_RD0, 32'h55);
        push("r7_busy_before_reset", K_BUSY0, 32'h1);
        check_pending();
        #20;
        rst_n = 1'b0;
        exp_pc = 32'h0;
        push("r7_async_reset", K_RD0, 32'h0);
        push("r7_busy_async_reset", K_BUSY0, 32'h0);
        push("pc_async_reset", K_PC, 32'h0);
        push("pc_read_async_reset", K_RD1, 32'h8);
        check_pending();
        // A write presented during reset is discarded.
        we1 = 1'b1; wa1 = 4'd3; wd1 = 32'h0000_DEAD;
        tick();
        we1 = 1'b0;
        #20;
        rst_n = 1'b1;
        rd_addr0 = 4'd3;
        push("r3_write_in_reset", K_RD0, 32'h0);
        check_pending();
        tick();
        push("pc_first_after_reset", K_PC, 32'h4);
        check_pending();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file_scoreboard.md
# register_file_scoreboard

Parametrised successor register file for the pipelined processor datapath. It provides:
- 2^AW registers of W bits, with the top register hard-wired as the program counter (PC).
- Two combinational read ports and two clocked write ports with defined collision priority.
- A self-advancing PC with load and stall control.
- A per-register busy scoreboard that the hazard unit uses to detect pending writebacks.

It sits between the decode stage (reads, issue) and the writeback stage (commits).

## Interface
Parameters:
- W, 32, data width in bits
- AW, 4, address width; register count NREG = 2^AW; PC index = NREG-1
- PC_STEP, 4, PC increment per advancing cycle
- PC_READ_OFFSET, 8, value added to PC when PC is read through a read port

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset_asynchronous_n  input  1  asynchronous, active-low reset
- inp_read_address0 / inp_read_address1  input  AW  read port selects
- out_read_data0 / out_read_data1  output  W  read data
- out_busy0 / out_busy1  output  1  busy bit of the register addressed by the matching read port
- write_enable0  input  1  write port 0 enable (ALU writeback)
- inp_write_address0  input  AW  write port 0 address
- inp_write_data0  input  W  write port 0 data
- write_enable1  input  1  write port 1 enable (memory writeback)
- inp_write_address1  input  AW  write port 1 address
- inp_write_data1  input  W  write port 1 data
- issue_valid  input  1  an instruction with a destination register issues this cycle
- inp_issue_address  input  AW  destination register of the issuing instruction
- pc_load  input  1  load PC from inp_pc_data
- inp_pc_data  input  W  branch target
- pc_stall  input  1  hold PC
- out_pc  output  W  current PC register value

## Operation
- GPRs R0..R(NREG-2):
  - A write port updates its register at the clock edge when its enable is high.
  - Both ports writing the same address in the same cycle: port 1 wins.
  - Writes addressed to the PC index are ignored.
- PC update, in priority order each cycle:
  1. pc_load: PC <= inp_pc_data.
  2. pc_stall: PC holds.
  3. Otherwise: PC <= PC + PC_STEP.
  - pc_load has priority over pc_stall.
  - Arithmetic is modulo 2^W.
- Reads:
  - A GPR address returns the register contents.
  - The PC index returns (PC + PC_READ_OFFSET) mod 2^W.
- Scoreboard, one busy bit per GPR:
  - Set by issue_valid at inp_issue_address.
  - Cleared by any enabled write port commit to that address.
  - Issue and commit to the same register in the same cycle: the bit ends set (the new producer wins).
  - Issue to the PC index is ignored; the PC is never busy.
- Reset (reset_asynchronous_n low, taking effect immediately and independent of clk):
  - All GPRs, PC and busy bits are cleared to 0.
  - Outputs during reset: out_read_data = 0 for GPR addresses and PC_READ_OFFSET for the PC index; out_busy = 0; out_pc = 0.
  - Reset asserted mid-operation discards any in-flight writes and pending busy bits.

## Timing
- Reads and busy outputs are combinational from registered state plus the bypass path (see Configuration). Read latency is 0 cycles.
- A write is visible in register state one cycle after it is presented.
- The PC advances every non-stalled cycle. out_pc changes only on clock edges and on reset.
- The first rising edge after reset release with no control inputs asserted gives out_pc = PC_STEP.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read of the same address as an enabled same-cycle write returns the write data (port 1 priority).
  - out_busy for that address reads 0 unless issue_valid targets it in the same cycle.
- Undefined:
  - Reads return pre-edge register contents.
  - out_busy reflects registered bits only, so a consumer stalls one extra cycle.
- PC reads are never bypassed.

## Structure
- Shared package holds:
  - Default W/AW constants.
  - PC index function NREG-1.
  - PC_STEP and PC_READ_OFFSET defaults.
  - Write-port priority constant.
- One natural sub-module: register_asynchronous_reset_write_en (W-bit register with active-low async reset and write enable), instantiated per GPR and for the PC.
- Write decode, read muxes and the scoreboard stay in the top module, generated over NREG.

## Test plan
- Reset then idle 3 cycles → out_pc = 0, 4, 8, 12. Reading address 15 gives out_pc + 8. All GPR reads and all busy bits are 0.
- Write 0xA5A5_0001 via port 0 to R3 and, in the same cycle, 0x0000_BEEF via port 1 to R3 → R3 reads 0x0000_BEEF next cycle. With REGFILE_BYPASS_EN, reading R3 in that same cycle already returns 0x0000_BEEF.
- issue_valid to R5, then port 1 commit to R5 two cycles later → out_busy for R5 is 1 for 2 cycles, then 0. Issue and commit to R5 in the same cycle → the bit stays 1.
- pc_stall held 2 cycles with PC = 0x20 → PC stays 0x20. pc_load with 0x100 while stalled → PC = 0x100. Next free cycle → 0x104.
- PC = 0xFFFF_FFFC advancing → wraps to 0x0000_0000. Port 0 write of 0x1234 to address 15 → ignored, PC unaffected.
- Drive reset_asynchronous_n low between clock edges while R7 = 0x55 and R7 is busy → R7 and its busy bit read 0 immediately, before the next clock edge.
